// File: rtl/bank_mapper_if.sv
// bank_mapper_if: Z80 bus and decoder outputs between CPU side (master) and bank_mapper (slave)
// Ports: mreq_n/ioreq_n/rfsh_n/wr_n/addr_i/data_i come from the CPU; data_o, phys_addr_o,
// rom_cs/ram_cs/uart_cs/kbd_cs/periph_cs/mapper_cs and wait_n come from the decoder.
interface bank_mapper_if #(
  parameter int PHYS_AW    = 19,
  parameter int NUM_PERIPH = 4
);
  logic                  mreq_n;
  logic                  ioreq_n;
  logic                  rfsh_n;
  logic                  wr_n;
  logic [15:0]           addr_i;
  logic [7:0]            data_i;
  logic [7:0]            data_o;
  logic [PHYS_AW-1:0]    phys_addr_o;
  logic                  rom_cs;
  logic                  ram_cs;
  logic                  uart_cs;
  logic                  kbd_cs;
  logic [NUM_PERIPH-1:0] periph_cs;
  logic                  mapper_cs;
  logic                  wait_n;
  modport master (
    output mreq_n, ioreq_n, rfsh_n, wr_n, addr_i, data_i,
    input  data_o, phys_addr_o, rom_cs, ram_cs, uart_cs, kbd_cs, periph_cs, mapper_cs, wait_n
  );
  modport slave (
    input  mreq_n, ioreq_n, rfsh_n, wr_n, addr_i, data_i,
    output data_o, phys_addr_o, rom_cs, ram_cs, uart_cs, kbd_cs, periph_cs, mapper_cs, wait_n
  );
endinterface

// File: rtl/bank_mapper.sv
// bank_mapper: nanoz80 paged memory mapper, ROM overlay, I/O decode and per-region wait states
// Ports: clk_i clock, rst_n_i async active-low reset, bus (bank_mapper_if.slave) carrying the
// Z80 requests/address/data in and the chip selects, physical address, read data and WAIT out.
module bank_mapper #(
  parameter int NUM_PAGES     = 4,
  parameter int PHYS_AW       = 19,
  parameter int ROM_SIZE_LOG2 = 13,
  parameter int NUM_PERIPH    = 4,
  parameter int ROM_WAIT      = 1,
  parameter int RAM_WAIT      = 0,
  parameter int IO_WAIT       = 1
) (
  input logic          clk_i,
  input logic          rst_n_i,
  bank_mapper_if.slave bus
);
  localparam int PB = NUM_PAGES == 4 ? 2 : NUM_PAGES == 2 ? 1 : 0;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;
  state_e     state_q, state_d;
  logic [7:0] page_q [4];
  logic [7:0] page_d [4];
  logic [7:0] io_bank_q, io_bank_d;
  logic       rom_dis_q, rom_dis_d, lock_q, lock_d, req_q, req_d;
  logic [2:0] cnt_q, cnt_d, ws;
  logic [7:0] port, pg;
  logic [1:0] pidx;
  logic       mem, io, req, start, we, ctrl_we;
  always_comb begin
    port = bus.addr_i[7:0];
    mem = !bus.mreq_n && bus.rfsh_n;
    io = !bus.ioreq_n && bus.rfsh_n;
    req = mem || io;
    start = req && !req_q;
    we = io && !bus.wr_n;
    ctrl_we = we && !lock_q && port == 8'h7E;
    // with PB = 0 the shift clears the index, so page_reg[0] serves the whole space
    pidx = 2'(bus.addr_i >> (16 - PB));
    pg = page_q[pidx];
    bus.rom_cs = mem && !rom_dis_q && (32'(bus.addr_i) >> ROM_SIZE_LOG2) == 0;
    bus.ram_cs = mem && !bus.rom_cs;
    bus.uart_cs = io && port[7:2] == 6'b011100;
    bus.kbd_cs = io && port[7:1] == 7'b0111010;
    bus.mapper_cs = io && port >= 8'h76 && port[7:4] == 4'h7;
    bus.periph_cs = (io && port[7:4] != 4'h7 && 32'(io_bank_q) < NUM_PERIPH) ? NUM_PERIPH'(1) << io_bank_q : '0;
    // page bits above the window shift out of PHYS_AW, which is the required truncation
    bus.phys_addr_o = (PHYS_AW'(pg) << (16 - PB)) | PHYS_AW'(bus.addr_i & (16'hFFFF >> PB));
    bus.data_o = (!bus.ioreq_n && port[7:3] == 5'b01111) ?
                 (port == 8'h7E ? {lock_q, 6'b0, rom_dis_q} :
                  port == 8'h7F ? io_bank_q :
                  32'(port[2:0]) < NUM_PAGES ? page_q[port[1:0]] : 8'h00) : 8'h00;
    for (int i = 0; i < 4; i++)
      page_d[i] = (we && !lock_q && i < NUM_PAGES && port == 8'(8'h78 + i)) ? bus.data_i : page_q[i];
    rom_dis_d = ctrl_we ? bus.data_i[0] : rom_dis_q;
    lock_d = ctrl_we ? bus.data_i[7] : lock_q;
    io_bank_d = (we && port == 8'h7F) ? bus.data_i : io_bank_q;
    ws = mem ? (bus.rom_cs ? 3'(ROM_WAIT) : 3'(RAM_WAIT)) : 3'(IO_WAIT);
    req_d = req;
    state_d = state_q == IDLE  ? (start ? (ws != 3'd0 ? COUNT : HOLD) : IDLE) :
              state_q == COUNT ? (!req ? IDLE : cnt_q == 3'd0 ? HOLD : COUNT) :
              (req ? HOLD : IDLE);
    cnt_d = state_q == IDLE ? ws - 3'd1 : cnt_q - 3'd1;
    // start cycle supplies the first low cycle, so COUNT stays low only while cnt is non-zero
    bus.wait_n = !(rst_n_i && ((state_q == IDLE && start && ws != 3'd0) ||
                               (state_q == COUNT && req && cnt_q != 3'd0)));
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) page_q[i] <= 8'(i);
      io_bank_q <= 8'h00;
      rom_dis_q <= 1'b0;
      lock_q <= 1'b0;
      req_q <= 1'b0;
      cnt_q <= 3'd0;
      state_q <= IDLE;
    end else begin
      page_q <= page_d;
      io_bank_q <= io_bank_d;
      rom_dis_q <= rom_dis_d;
      lock_q <= lock_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_bank_mapper.sv
// tb_bank_mapper: directed checks of bank_mapper decode, mapping, lock and wait-state timing
module tb_bank_mapper;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic mreq_n = 1'b1, ioreq_n = 1'b1, rfsh_n = 1'b1, wr_n = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0] din = '0;
  bank_mapper_if b ();
  bank_mapper_if r ();
  assign b.mreq_n = mreq_n;
  assign b.ioreq_n = ioreq_n;
  assign b.rfsh_n = rfsh_n;
  assign b.wr_n = wr_n;
  assign b.addr_i = addr;
  assign b.data_i = din;
  assign r.mreq_n = mreq_n;
  assign r.ioreq_n = ioreq_n;
  assign r.rfsh_n = rfsh_n;
  assign r.wr_n = wr_n;
  assign r.addr_i = addr;
  assign r.data_i = din;
  bank_mapper dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(b));
  bank_mapper #(.ROM_WAIT(3)) dut_r (.clk_i(clk), .rst_n_i(rst_n), .bus(r));
  int n_chk = 0, n_pass = 0, nb, nr;
  logic s_rom, s_ram, s_uart, s_kbd, s_map;
  logic [3:0] s_per;
  logic [18:0] s_phys;
  logic [7:0] s_db, s_dr;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  task automatic cyc(input logic m, input logic io, input logic rf, input logic w,
                     input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    mreq_n = !m; ioreq_n = !io; rfsh_n = rf; wr_n = !w; addr = a; din = d;
    @(negedge clk);
    s_rom = b.rom_cs; s_ram = b.ram_cs; s_uart = b.uart_cs; s_kbd = b.kbd_cs;
    s_map = b.mapper_cs; s_per = b.periph_cs; s_phys = b.phys_addr_o;
    s_db = b.data_o; s_dr = r.data_o;
    nb = 0; nr = 0;
    for (int k = 0; k < 10; k++) begin
      if (b.wait_n && r.wait_n) break;
      if (!b.wait_n) nb++;
      if (!r.wait_n) nr++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mreq_n = 1'b1; ioreq_n = 1'b1; rfsh_n = 1'b1; wr_n = 1'b1;
  endtask
  task automatic wr_io(input logic [7:0] p, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, {8'h00, p}, d);
  endtask
  task automatic rd_io(input logic [7:0] p);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, {8'h00, p}, 8'h00);
  endtask
  task automatic rd_mem(input logic [15:0] a);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait", b.wait_n, 1);
    rst_n = 1'b1;
    rd_io(8'h79); check("rst_page1", s_db, 8'h01);
    rd_io(8'h7E); check("rst_ctrl", s_db, 8'h00);
    rd_io(8'h7F); check("rst_iobank", s_db, 8'h00);
    rd_mem(16'h0100);
    check("rom_cs_0100", s_rom, 1); check("ram_cs_0100", s_ram, 0);
    check("phys_0100", s_phys, 19'h00100); check("rom_waits", nb, 1); check("rom3_waits", nr, 3);
    rd_mem(16'hC123);
    check("ram_cs_C123", s_ram, 1); check("rom_cs_C123", s_rom, 0);
    check("phys_C123", s_phys, 19'h0C123); check("ram_waits", nb, 0);
    rd_mem(16'h1FFF); check("rom_edge_in", s_rom, 1); check("phys_1FFF", s_phys, 19'h01FFF);
    rd_mem(16'h2000); check("rom_edge_out", s_rom, 0); check("ram_2000", s_ram, 1);
    rd_mem(16'h4000); check("phys_4000", s_phys, 19'h04000);
    wr_io(8'h7B, 8'h1F);
    rd_mem(16'hC123); check("phys_paged", s_phys, 19'h7C123);
    rd_io(8'h7B);
    check("rd_page3", s_db, 8'h1F); check("mapper_cs", s_map, 1); check("io_waits", nb, 1);
    rd_io(8'h7C); check("rd_unused", s_db, 8'h00);
    wr_io(8'h7E, 8'h81);
    wr_io(8'h7E, 8'h00);
    wr_io(8'h78, 8'h05);
    rd_io(8'h7E); check("locked_ctrl", s_db, 8'h81);
    rd_io(8'h78); check("locked_page0", s_db, 8'h00);
    rd_mem(16'h0000); check("romdis_ram", s_ram, 1); check("romdis_rom", s_rom, 0);
    wr_io(8'h7F, 8'h02);
    rd_io(8'h7F); check("iobank_wr", s_db, 8'h02);
    rd_io(8'h80);
    check("periph_b2", s_per, 4'b0100); check("periph_waits", nb, 1); check("periph_uart", s_uart, 0);
    wr_io(8'h7F, 8'h09);
    rd_io(8'h80); check("periph_b9", s_per, 4'b0000);
    rd_io(8'h71);
    check("uart_cs", s_uart, 1); check("uart_kbd", s_kbd, 0);
    check("uart_map", s_map, 0); check("uart_per", s_per, 0);
    rd_io(8'h75); check("kbd_cs", s_kbd, 1); check("kbd_uart", s_uart, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 8'h00);
    check("rfsh_rom", s_rom, 0); check("rfsh_ram", s_ram, 0); check("rfsh_waits", nb, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h007F, 8'h33);
    check("rfsh_io_map", s_map, 0); check("rfsh_io_waits", nb, 0);
    rd_io(8'h7F); check("rfsh_no_write", s_db, 8'h09);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_io(8'h7B, 8'h1F);
    @(posedge clk);
    #1;
    mreq_n = 1'b0; addr = 16'h0100;
    @(negedge clk);
    check("r_start_wait", r.wait_n, 0); check("r_rom_cs", r.rom_cs, 1);
    @(negedge clk);
    check("r_count_wait", r.wait_n, 0);
    #1 mreq_n = 1'b1;
    #1 check("r_abort_wait", r.wait_n, 1);
    @(negedge clk);
    check("r_idle_wait", r.wait_n, 1);
    rd_mem(16'h0100); check("r_after_abort", nr, 3); check("b_after_abort", nb, 1);
    @(posedge clk);
    #1;
    mreq_n = 1'b0; addr = 16'h0100;
    @(negedge clk);
    @(posedge clk);
    #1 check("r_pre_rst", r.wait_n, 0);
    rst_n = 1'b0;
    #1 check("r_rst_wait", r.wait_n, 1);
    @(posedge clk);
    #1;
    mreq_n = 1'b1;
    rst_n = 1'b1;
    rd_io(8'h7B); check("r_rst_page3", s_dr, 8'h03);
    rd_io(8'h7E); check("r_rst_ctrl", s_dr, 8'h00);
    rd_mem(16'h0100); check("r_rst_waits", nr, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
